// File: rtl/npu_sequencer_pkg.sv
// Shared types and constants for the NPU run sequencer.
// Provides the FSM state encoding and the dataflow mode codes.
package npu_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DRAIN   = 2'd2
   } seq_state_e;

   localparam int MODE_IS = 0;
   localparam int MODE_WS = 1;

endpackage

// File: rtl/npu_sequencer_if.sv
// Host command channel of the NPU run sequencer (valid/ready handshake).
// Ports: cmd_valid, cmd_mode, cmd_len from host; cmd_ready back to host.
interface npu_sequencer_if #(
   parameter int MODE_W = 2,
   parameter int CNT_W  = 17
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [MODE_W-1:0] cmd_mode;
   logic [CNT_W-1:0]  cmd_len;

   modport master (
      output cmd_valid,
      output cmd_mode,
      output cmd_len,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_mode,
      input  cmd_len,
      output cmd_ready
   );
endinterface

// File: rtl/npu_sequencer_enable_delay_line.sv
// Shift register that replays the PE enable DEPTH cycles later.
// Ports: clk, reset, din (enable in), dout (delayed enable),
//        any_set (an enable is still in flight after this edge).
module enable_delay_line #(
   parameter int DEPTH = 17
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic any_set
);

   logic [DEPTH-1:0] stage;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk) begin
            if (reset) stage <= '0;
            else       stage <= din;
         end
         assign any_set = din;
      end else begin : g_many
         always_ff @(posedge clk) begin
            if (reset) stage <= '0;
            else       stage <= {stage[DEPTH-2:0], din};
         end
         // Look one edge ahead: the last stage retires now, so only
         // din and the lower stages can still be non-zero next cycle.
         assign any_set = din | (|stage[DEPTH-2:0]);
      end
   endgenerate

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/npu_sequencer.sv
// NPU run controller: accepts mode+length commands, gates PE/preprocess
// enables on buffer readiness, delays them to the output buffer, drains.
// Ports: clk, reset, cmd (command channel), buf_ready, pe_array_enable,
//        data_preprocessing_unit_enable, output_buffer_enable,
//        dataflow_mode, busy, done, err.
module npu_sequencer
   import npu_sequencer_pkg::*;
#(
   parameter int NUM_BUFS   = 3,
   parameter int CNT_W      = 17,
   parameter int PE_LATENCY = 17,
   parameter int MODE_W     = 2
) (
   input  logic                clk,
   input  logic                reset,
   npu_sequencer_if.slave      cmd,
   input  logic [NUM_BUFS-1:0] buf_ready,
   output logic                pe_array_enable,
   output logic                data_preprocessing_unit_enable,
   output logic                output_buffer_enable,
   output logic                dataflow_mode,
   output logic                busy,
   output logic                done,
   output logic                err
);

   seq_state_e       state;
   logic [CNT_W-1:0] remaining;
   logic             fire;
   logic             cmd_legal;
   logic             in_flight;

   assign cmd.cmd_ready = (state == S_IDLE);
   assign busy          = (state != S_IDLE);

   assign cmd_legal = (cmd.cmd_mode <= MODE_W'(MODE_WS))
                    && (cmd.cmd_len != '0);

   assign fire = (state == S_COMPUTE) && (&buf_ready)
               && (remaining != '0);

   enable_delay_line #(
      .DEPTH(PE_LATENCY)
   ) u_delay (
      .clk     (clk),
      .reset   (reset),
      .din     (pe_array_enable),
      .dout    (output_buffer_enable),
      .any_set (in_flight)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state                          <= S_IDLE;
         remaining                      <= '0;
         pe_array_enable                <= 1'b0;
         data_preprocessing_unit_enable <= 1'b0;
         dataflow_mode                  <= 1'b0;
         done                           <= 1'b0;
         err                            <= 1'b0;
      end else begin
         pe_array_enable                <= fire;
         data_preprocessing_unit_enable <= fire;
         done                           <= 1'b0;
         err                            <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (cmd.cmd_valid) begin
                  if (!cmd_legal) begin
                     err <= 1'b1;
                  end else begin
                     state         <= S_COMPUTE;
                     remaining     <= cmd.cmd_len;
                     dataflow_mode <= (cmd.cmd_mode != MODE_W'(MODE_IS));
                  end
               end
            end
            S_COMPUTE: begin
               if (fire) begin
                  remaining <= remaining - CNT_W'(1);
                  if (remaining == CNT_W'(1)) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // done is raised for one cycle while still in DRAIN,
               // so cmd_ready only returns in the cycle after it.
               if (done)            state <= S_IDLE;
               else if (!in_flight) done  <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
